// File: rtl/spr_unit_pkg.sv
// Shared SPR index map, reset values and the cause priority encoder.
package spr_pkg;

  localparam int unsigned SPR_SR    = 0;
  localparam int unsigned SPR_ESR   = 1;
  localparam int unsigned SPR_ECA   = 2;
  localparam int unsigned SPR_EPC   = 3;
  localparam int unsigned SPR_EDPC  = 4;
  localparam int unsigned SPR_EDATA = 5;
  localparam int unsigned SPR_EMODE = 6;
  localparam int unsigned SPR_MODE  = 7;
  // First scratch index; everything below is architectural state.
  localparam int unsigned SPR_FIXED = 8;

  localparam logic [31:0] SPR_RST_VAL  = 32'd0;
  localparam logic [31:0] MODE_RST_VAL = 32'd1;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [63:0] v);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (v[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/spr_unit_if.sv
// Writeback-side bus of the SPR unit: pipeline context in, SPR/interrupt state out.
interface spr_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AW      = 3,
  parameter int unsigned CAUSE_W = 23,
  parameter int unsigned N_EXT   = 8,
  parameter int unsigned CW      = 5
);
  logic                        commit;
  logic [CAUSE_W-N_EXT-1:0]    ca_int;
  logic [N_EXT-1:0]            ext_irq;
  logic                        eret;
  logic [DATA_W-1:0]           pc;
  logic [DATA_W-1:0]           next_pc;
  logic [DATA_W-1:0]           ea;
  logic                        sprw;
  logic [AW-1:0]               reg_sel;
  logic [DATA_W-1:0]           data_in;
  logic                        jisr;
  logic [CW-1:0]               prio_idx;
  logic [DATA_W-1:0]           spr_out;
  logic [DATA_W-1:0]           mode;
  logic [DATA_W-1:0]           epc;

  modport master (
    output commit, ca_int, ext_irq, eret, pc, next_pc, ea, sprw, reg_sel, data_in,
    input  jisr, prio_idx, spr_out, mode, epc
  );

  modport slave (
    input  commit, ca_int, ext_irq, eret, pc, next_pc, ea, sprw, reg_sel, data_in,
    output jisr, prio_idx, spr_out, mode, epc
  );
endinterface

// File: rtl/spr_unit_irq_latch.sv
// Edge detector and sticky pending latch for the external interrupt lines.
module irq_latch #(
  parameter int unsigned N_EXT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic [N_EXT-1:0] clr,
  output logic [N_EXT-1:0] pend
);

  logic [N_EXT-1:0] ext_q;
  logic [N_EXT-1:0] rise;

  assign rise = ext_irq & ~ext_q;

  // Track previous line level; a fresh edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q <= '0;
      pend  <= '0;
    end else begin
      ext_q <= ext_irq;
      pend  <= (pend & ~clr) | rise;
    end
  end

endmodule

// File: rtl/spr_unit.sv
// Special-purpose register file with interrupt masking, context save on jisr
// and context restore on eret.
module spr_unit
  import spr_pkg::*;
#(
  parameter int unsigned DATA_W              = 32,
  parameter int unsigned NUM_SPR             = 8,
  parameter int unsigned CAUSE_W             = 23,
  parameter int unsigned N_EXT               = 8,
  parameter int unsigned MASK_LO             = 12,
  parameter logic [CAUSE_W-1:0] REPEAT_MASK  = 'h0000C0,
  localparam int unsigned AW                 = $clog2(NUM_SPR),
  localparam int unsigned CW                 = $clog2(CAUSE_W)
) (
  input  logic     clk,
  input  logic     rst_n,
  spr_unit_if.slave bus
);

  localparam logic [AW-1:0] A_SR    = AW'(SPR_SR);
  localparam logic [AW-1:0] A_ESR   = AW'(SPR_ESR);
  localparam logic [AW-1:0] A_ECA   = AW'(SPR_ECA);
  localparam logic [AW-1:0] A_EPC   = AW'(SPR_EPC);
  localparam logic [AW-1:0] A_EDPC  = AW'(SPR_EDPC);
  localparam logic [AW-1:0] A_EDATA = AW'(SPR_EDATA);
  localparam logic [AW-1:0] A_EMODE = AW'(SPR_EMODE);
  localparam logic [AW-1:0] A_MODE  = AW'(SPR_MODE);

  logic [DATA_W-1:0]  spr     [NUM_SPR];
  logic [DATA_W-1:0]  spr_d   [NUM_SPR];
  logic [DATA_W-1:0]  spr_rst [NUM_SPR];

  logic [N_EXT-1:0]   pend;
  logic [N_EXT-1:0]   clr;
  logic [CAUSE_W-1:0] ca;
  logic [CAUSE_W-1:0] mca;
  logic [CAUSE_W-1:0] rpt_mask;
  logic [CW-1:0]      prio;
  logic               any_cause;
  logic               jisr;
  logic               rpt;
  logic               eret_take;
  logic               sel_ok;
  logic               sel_arch;
  logic               wr_allowed;

  irq_latch #(.N_EXT(N_EXT)) u_irq_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .ext_irq (bus.ext_irq),
    .clr     (clr),
    .pend    (pend)
  );

  assign ca = {pend, bus.ca_int};

  // Causes below MASK_LO are non-maskable; the rest are gated by SR.
  for (genvar g = 0; g < CAUSE_W; g++) begin : g_mask
    if (g < MASK_LO) begin : g_nmi
      assign mca[g] = ca[g];
    end else begin : g_msk
      assign mca[g] = ca[g] & spr[A_SR][g];
    end
  end

  // Indices past NUM_SPR only exist when the count is not a power of two.
  if (NUM_SPR == (1 << AW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = (bus.reg_sel < AW'(NUM_SPR));
  end

  if (NUM_SPR > SPR_FIXED) begin : g_scratch
    assign sel_arch = (bus.reg_sel < AW'(SPR_FIXED));
  end else begin : g_no_scratch
    assign sel_arch = 1'b1;
  end

  assign rpt_mask  = REPEAT_MASK;
  assign any_cause = |mca;
  assign prio      = CW'(lowest_set(64'(mca)));
  assign rpt       = rpt_mask[prio] & any_cause;
  assign jisr      = bus.commit & any_cause;
  assign eret_take = bus.eret & bus.commit & ~jisr;
  assign clr       = jisr ? mca[CAUSE_W-1 -: N_EXT] : '0;

  // Architectural registers lose writes that collide with save/restore.
  assign wr_allowed = !(jisr && sel_arch) &&
                      !(eret_take && (bus.reg_sel == A_SR || bus.reg_sel == A_MODE));

  // Reset image: everything clear except MODE.
  always_comb begin
    spr_rst         = '{default: '0};
    spr_rst[A_SR]   = DATA_W'(SPR_RST_VAL);
    spr_rst[A_MODE] = DATA_W'(MODE_RST_VAL);
  end

  // Next-state: write, then restore, then save; later steps take precedence.
  always_comb begin
    spr_d = spr;
    if (bus.sprw && sel_ok && wr_allowed) begin
      spr_d[bus.reg_sel] = bus.data_in;
    end
    if (eret_take) begin
      spr_d[A_SR]   = spr[A_ESR];
      spr_d[A_MODE] = spr[A_EMODE];
    end
    if (jisr) begin
      spr_d[A_ESR]   = spr[A_SR];
      spr_d[A_SR]    = '0;
      spr_d[A_ECA]   = DATA_W'(mca);
      spr_d[A_EPC]   = rpt ? bus.pc : bus.next_pc;
      spr_d[A_EDPC]  = bus.next_pc;
      spr_d[A_EDATA] = bus.ea;
      spr_d[A_EMODE] = spr[A_MODE];
      spr_d[A_MODE]  = DATA_W'(MODE_RST_VAL);
    end
  end

  // Register array update; reset overrides any in-flight save/restore.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spr <= spr_rst;
    end else begin
      spr <= spr_d;
    end
  end

  assign bus.jisr     = jisr;
  assign bus.prio_idx = prio;
  assign bus.spr_out  = sel_ok ? spr[bus.reg_sel] : '0;
  assign bus.mode     = spr[A_MODE];
  assign bus.epc      = spr[A_EPC];

endmodule

// File: tb/tb_spr_unit.sv
// Scoreboard bench for spr_unit: directed scenarios plus random traffic
// against a behavioural model of the SPR/interrupt rules.
module tb_spr_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 12;
  localparam int unsigned AWB = 4;
  localparam int unsigned CWD = 23;
  localparam int unsigned NE  = 8;
  localparam int unsigned CWB = 5;
  localparam int unsigned MLO = 12;
  localparam logic [22:0] RPT = 23'h0000C0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spr_unit_if #(.DATA_W(DW), .AW(AWB), .CAUSE_W(CWD), .N_EXT(NE), .CW(CWB)) bus ();

  spr_unit #(
    .DATA_W      (DW),
    .NUM_SPR     (NS),
    .CAUSE_W     (CWD),
    .N_EXT       (NE),
    .MASK_LO     (MLO),
    .REPEAT_MASK (RPT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit        jisr;
    int        prio;
    bit [31:0] spr_out;
    bit [31:0] mode;
    bit [31:0] epc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state
  bit [31:0] m_spr [NS];
  bit [7:0]  m_pend;
  bit [7:0]  m_extq;

  // Stimulus for the current cycle
  bit        t_rst_n, t_commit, t_eret, t_sprw;
  bit [14:0] t_ca;
  bit [7:0]  t_ext;
  bit [31:0] t_pc, t_npc, t_ea, t_data;
  bit [3:0]  t_sel;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) m_spr[i] = 32'd0;
    m_spr[7] = 32'd1;
    m_pend   = 8'd0;
    m_extq   = 8'd0;
  endfunction

  // Unmasked causes and the lowest-numbered one.
  function automatic void causes(output bit [22:0] mca, output int prio);
    bit [22:0] ca;
    ca   = {m_pend, t_ca};
    mca  = '0;
    prio = 0;
    for (int i = 0; i < 23; i++)
      if (ca[i] && (i < MLO || m_spr[0][i])) mca[i] = 1'b1;
    for (int i = 22; i >= 0; i--)
      if (mca[i]) prio = i;
  endfunction

  function automatic void model_step(input bit [22:0] mca, input int prio, input bit take);
    bit [31:0] old [NS];
    bit [22:0] rm;
    bit [7:0]  clr;
    bit        eret_take;
    bit        rpt;
    if (!t_rst_n) begin
      model_reset();
      return;
    end
    rm        = RPT;
    rpt       = rm[prio] && (mca != 0);
    clr       = take ? mca[22:15] : 8'd0;
    m_pend    = (m_pend & ~clr) | (t_ext & ~m_extq);
    m_extq    = t_ext;
    old       = m_spr;
    eret_take = t_eret && t_commit && !take;
    if (t_sprw && t_sel < NS) begin
      if (t_sel >= 8) m_spr[t_sel] = t_data;
      else if (!take && !(eret_take && (t_sel == 0 || t_sel == 7))) m_spr[t_sel] = t_data;
    end
    if (eret_take) begin
      m_spr[0] = old[1];
      m_spr[7] = old[6];
    end
    if (take) begin
      m_spr[1] = old[0];
      m_spr[0] = 32'd0;
      m_spr[2] = {9'd0, mca};
      m_spr[3] = rpt ? t_pc : t_npc;
      m_spr[4] = t_npc;
      m_spr[5] = t_ea;
      m_spr[6] = old[7];
      m_spr[7] = 32'd1;
    end
  endfunction

  task automatic drive();
    rst_n       = t_rst_n;
    bus.commit  = t_commit;
    bus.ca_int  = t_ca;
    bus.ext_irq = t_ext;
    bus.eret    = t_eret;
    bus.pc      = t_pc;
    bus.next_pc = t_npc;
    bus.ea      = t_ea;
    bus.sprw    = t_sprw;
    bus.reg_sel = t_sel;
    bus.data_in = t_data;
  endtask

  task automatic idle();
    t_rst_n = 1'b1; t_commit = 1'b0; t_eret = 1'b0; t_sprw = 1'b0;
    t_ca = '0; t_ext = '0; t_pc = '0; t_npc = '0; t_ea = '0; t_data = '0; t_sel = '0;
  endtask

  // One clock: apply stimulus, queue expectation, optional spot check, advance model.
  task automatic cyc(input int kind = 0, input logic [31:0] exp = 0, input string nm = "");
    bit [22:0] mca;
    int        prio;
    exp_t      e;
    drive();
    causes(mca, prio);
    e.jisr    = t_commit && (mca != 0);
    e.prio    = prio;
    e.spr_out = (t_sel < NS) ? m_spr[t_sel] : 32'd0;
    e.mode    = m_spr[7];
    e.epc     = m_spr[3];
    q.push_back(e);
    #2;
    if (kind == 1) check(nm, bus.spr_out, exp);
    if (kind == 2) check(nm, 32'(bus.prio_idx), exp);
    if (kind == 3) check(nm, 32'(bus.jisr), exp);
    @(posedge clk);
    model_step(mca, prio, e.jisr);
    #1;
  endtask

  task automatic rd(input bit [3:0] sel, input logic [31:0] exp, input string nm);
    idle();
    t_sel = sel;
    cyc(1, exp, nm);
  endtask

  task automatic wr(input bit [3:0] sel, input bit [31:0] d);
    idle();
    t_sprw = 1'b1; t_sel = sel; t_data = d;
    cyc();
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_jisr",    32'(bus.jisr),     32'(e.jisr));
        check("sb_prio",    32'(bus.prio_idx), e.prio);
        check("sb_spr_out", bus.spr_out,       e.spr_out);
        check("sb_mode",    bus.mode,          e.mode);
        check("sb_epc",     bus.epc,           e.epc);
      end
    end
  end

  initial begin
    idle();
    t_rst_n = 1'b0;
    drive();
    @(posedge clk);
    model_reset();
    #1;

    // Reset state of every architectural index
    for (int i = 0; i < 8; i++) rd(4'(i), (i == 7) ? 32'd1 : 32'd0, "reset_read");

    // Repeat-class internal cause
    idle();
    t_commit = 1'b1; t_ca = 15'h0040; t_pc = 32'h100; t_npc = 32'h104; t_ea = 32'hABC;
    cyc(2, 32'd6, "int6_prio");
    rd(4'd2, 32'h40,  "int6_eca");
    rd(4'd3, 32'h100, "int6_epc");
    rd(4'd5, 32'hABC, "int6_edata");
    rd(4'd0, 32'h0,   "int6_sr");
    rd(4'd7, 32'h1,   "int6_mode");

    // Unmasked external edge on line 0
    wr(4'd0, 32'h7FF000);
    idle(); t_ext = 8'h01; cyc();
    idle(); t_commit = 1'b1; t_pc = 32'h200; t_npc = 32'h204;
    cyc(2, 32'd15, "ext0_prio");
    rd(4'd2, 32'h8000, "ext0_eca");
    rd(4'd3, 32'h204,  "ext0_epc");
    idle(); t_commit = 1'b1; cyc(3, 32'd0, "ext0_cleared");

    // Masked edge persists until SR enables it
    idle(); t_ext = 8'h08; cyc();
    idle(); t_commit = 1'b1; cyc(3, 32'd0, "ext3_masked");
    wr(4'd0, 32'h040000);
    idle(); t_commit = 1'b1; cyc(2, 32'd18, "ext3_prio");

    // Save and restore of SR/MODE
    wr(4'd0, 32'h123000);
    wr(4'd7, 32'h0);
    idle(); t_commit = 1'b1; t_ca = 15'h0002; t_npc = 32'h300; cyc(3, 32'd1, "save_jisr");
    idle(); t_commit = 1'b1; t_eret = 1'b1; cyc(3, 32'd0, "eret_no_jisr");
    rd(4'd0, 32'h123000, "eret_sr");
    rd(4'd7, 32'h0,      "eret_mode");

    // jisr + eret + sprw collide
    idle(); t_commit = 1'b1; t_ca = 15'h0001; t_eret = 1'b1;
    t_sprw = 1'b1; t_sel = 4'd2; t_data = 32'hFFFF;
    cyc(3, 32'd1, "collide_jisr");
    rd(4'd2, 32'h1, "collide_eca");
    rd(4'd0, 32'h0, "collide_sr");
    rd(4'd7, 32'h1, "collide_mode");
    idle(); t_commit = 1'b1; t_ca = 15'h0001; t_sprw = 1'b1; t_sel = 4'd8; t_data = 32'h5A5A;
    cyc();
    rd(4'd8, 32'h5A5A, "scratch_during_jisr");
    wr(4'd13, 32'hDEAD);
    rd(4'd13, 32'h0, "oob_read");

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      t_rst_n  = ($urandom_range(0, 99) != 0);
      t_commit = $urandom_range(0, 1) != 0;
      t_ca     = ($urandom_range(0, 7) == 0) ? 15'(1 << $urandom_range(0, 14)) : 15'd0;
      if ($urandom_range(0, 3) == 0) t_ext = t_ext ^ 8'(1 << $urandom_range(0, 7));
      t_eret   = ($urandom_range(0, 5) == 0);
      t_sprw   = ($urandom_range(0, 2) == 0);
      t_sel    = 4'($urandom_range(0, 15));
      t_data   = $urandom;
      t_pc     = $urandom;
      t_npc    = $urandom;
      t_ea     = $urandom;
      cyc();
    end

    idle();
    drive();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spr_unit.md
# spr_unit

Parametrised special-purpose register file with an integrated interrupt front end. The block edge-latches external interrupt requests, masks them against the status register, and raises `jisr` in the writeback stage when a committed instruction has an unmasked cause. On `jisr` it atomically saves the machine context; on `eret` it restores it. It replaces the fixed 8×32 SPR bank and sits beside the GPR file, feeding `mode` to the memory and privilege logic and `spr_out` to the `movs2i` datapath.

## Interface
- `DATA_W`, 32, SPR width (≥ `CAUSE_W`).
- `NUM_SPR`, 8, SPR count (≥ 8); indices 8 and up are scratch registers.
- `CAUSE_W`, 23, total cause vector width.
- `N_EXT`, 8, external edge-latched causes; these occupy the top bits of the cause vector.
- `MASK_LO`, 12, causes at indices ≥ `MASK_LO` are maskable via SR.
- `REPEAT_MASK`, 23'h0000C0, causes that mark the instruction for repeat.

Derived: `AW = $clog2(NUM_SPR)`, `CW = $clog2(CAUSE_W)`.

Ports:
- `clk` in 1, clock.
- `rst_n` in 1, synchronous, active-low.
- `commit` in 1, writeback instruction valid this cycle.
- `ca_int` in `CAUSE_W-N_EXT`, level internal causes from the pipeline.
- `ext_irq` in `N_EXT`, asynchronous-free external request lines, sampled on `clk`.
- `eret` in 1, return-from-exception committing.
- `pc`, `next_pc`, `ea` in `DATA_W`, context of the writeback instruction.
- `sprw` in 1, SPR write enable.
- `reg_sel` in `AW`, read/write index.
- `data_in` in `DATA_W`, SPR write data.
- `jisr` out 1, take interrupt (combinational).
- `prio_idx` out `CW`, lowest set bit of `mca`.
- `spr_out` out `DATA_W`, `spr[reg_sel]`, combinational.
- `mode` out `DATA_W`, MODE register.
- `epc` out `DATA_W`, EPC register, used as the `eret` target.

## Operation
- SPR map:
  - 0 SR (mask)
  - 1 ESR
  - 2 ECA
  - 3 EPC
  - 4 EDPC
  - 5 EDATA
  - 6 EMODE
  - 7 MODE
  - 8..`NUM_SPR-1` scratch
- `rise = ext_irq & ~ext_q`, where `ext_q` is the registered previous `ext_irq`.
- `pend_next = (pend & ~clr) | rise`. A new edge wins over a clear on the same bit.
- `ca = {pend, ca_int}`.
- `mca[i] = ca[i] & (i < MASK_LO | SR[i])`.
- `jisr = commit & |mca`.
- `prio_idx` is the lowest set index of `mca`, or 0 when `mca` is 0.
- `rpt = REPEAT_MASK[prio_idx] & |mca`.
- On `jisr`, in one clock:
  - ESR ← SR
  - SR ← 0
  - ECA ← zero-extended `mca`
  - EPC ← `rpt ? pc : next_pc`
  - EDPC ← `next_pc`
  - EDATA ← `ea`
  - EMODE ← MODE
  - MODE ← 1
  - `clr` = `mca[CAUSE_W-1:CAUSE_W-N_EXT]`
- On `eret & commit & ~jisr`: SR ← ESR, MODE ← EMODE.
- `sprw` writes `spr[reg_sel] ← data_in`, except when:
  - `jisr` is active and `reg_sel` is 0–7: the write is dropped.
  - `eret` is active and `reg_sel` is 0 or 7: the write is dropped.
  - Scratch registers are always written.
- `sprw` with `reg_sel ≥ NUM_SPR` (non-power-of-two counts) is ignored. Reads at such an index return 0.
- Priority: `jisr` > `eret` > `sprw`.

## Timing
- Reset (`rst_n = 0` at a clock edge): every SPR is 0 except MODE = 1. `pend` = 0, `ext_q` = 0.
  - Resulting outputs: `mode` = 1, `epc` = 0, `spr_out` = 0, and `jisr` = 0 unless an internal non-maskable cause is present.
- Reset asserted mid-interrupt overrides all updates in that cycle.
- `jisr`, `prio_idx` and `spr_out` are combinational. All register updates are visible on the cycle after the edge.
- External latency: an `ext_irq` rise at edge n sets `pend` at edge n+1, so `jisr` can assert in cycle n+1 given `commit` and the SR bit.
- Masked pending bits persist until they are unmasked and serviced.
- A level held high on `ext_irq` does not re-pend; only edges do.
- Back-to-back: SR = 0 after `jisr` blocks nesting of maskable causes. Non-maskable causes can still nest and overwrite the saved context.
- Same-cycle `jisr` and `eret`: `eret` is suppressed.

## Structure
- Package `spr_pkg` holds:
  - `localparam` SPR indices (`SPR_SR` through `SPR_MODE`).
  - Reset values.
  - A priority-encoder function.
- Sub-module `irq_latch` (parameter `N_EXT`) contains `ext_q`, `pend`, rise detection and `clr`.
- The register array, save/restore and write arbitration stay in `spr_unit`.

## Test plan
- Reset then read each index 0–7 → all 0 except MODE (index 7) = 1; `jisr` = 0.
- `ca_int` bit 6 set (in `REPEAT_MASK`), `commit`=1, `pc`=0x100, `next_pc`=0x104, `ea`=0xABC → `jisr`=1, `prio_idx`=6; next cycle EPC=0x100, ECA=0x40, EDATA=0xABC, SR=0, MODE=1.
- SR=0x7FF000, pulse `ext_irq[0]` (cause 15) → `pend` set next cycle, `jisr`=1 with `commit`; after taking it, ECA=0x8000, EPC=`next_pc`, `pend`=0.
- SR=0 and `ext_irq[3]` edge → no `jisr` (maskable); write SR=0x040000 via `sprw` → `jisr` the cycle after, `prio_idx`=18.
- Write SR=0x123000 and MODE=0 via `sprw`, take `jisr`, then `eret`+`commit` → SR=0x123000, MODE=0 restored.
- Simultaneous `jisr`, `eret` and `sprw` to index 2 with 0xFFFF → ECA = `mca` (write dropped), SR=0, `eret` ignored; `sprw` to index 8 in the same cycle succeeds.
